// File: rtl/multi_debounce.sv
// multi_debounce: N-channel debouncer with independent press/release qualification.
//   Each channel has its own synchroniser, a 4-state FSM and a stability counter.
// Ports:
//   clk         system clock
//   rst_n       asynchronous, active-low reset
//   noisy_in    raw asynchronous inputs, one bit per channel
//   clean_out   debounced level per channel (registered)
//   rise_pulse  one-cycle pulse in the first cycle clean_out shows 1
//   fall_pulse  one-cycle pulse in the first cycle clean_out shows 0
//   any_change  OR of all rise/fall pulses, same cycle (registered)
module multi_debounce #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned RISE_CYCLES = 500000,
    parameter int unsigned FALL_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

    // Thresholds must be representable and non-zero.
    if (RISE_CYCLES == 0 || 64'(RISE_CYCLES) >= CNT_SPAN) begin : g_bad_rise
        $error("multi_debounce: RISE_CYCLES must be in [1, 2**CNT_W)");
    end
    if (FALL_CYCLES == 0 || 64'(FALL_CYCLES) >= CNT_SPAN) begin : g_bad_fall
        $error("multi_debounce: FALL_CYCLES must be in [1, 2**CNT_W)");
    end

    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CYCLES - 1);

    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        HI_WAIT   = 2'd1,
        HI_STABLE = 2'd2,
        LO_WAIT   = 2'd3
    } state_t;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] clean_nxt;

    // Synchroniser chain, all channels side by side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= noisy_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;

        // State and stability counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= LO_STABLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Qualification: any opposite sample while waiting aborts to the old stable state.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                LO_STABLE: begin
                    cnt_nxt = '0;
                    if (sync_s[i]) state_nxt = HI_WAIT;
                end
                HI_WAIT: begin
                    if (!sync_s[i]) begin
                        state_nxt = LO_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == RISE_LAST) begin
                        state_nxt = HI_STABLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                HI_STABLE: begin
                    cnt_nxt = '0;
                    if (!sync_s[i]) state_nxt = LO_WAIT;
                end
                LO_WAIT: begin
                    if (sync_s[i]) begin
                        state_nxt = HI_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == FALL_LAST) begin
                        state_nxt = LO_STABLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = LO_STABLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Clean level follows the state it is registered with.
        assign clean_nxt[i] = (state_nxt == HI_STABLE) || (state_nxt == LO_WAIT);
    end

    // Level and edge pulses registered together so pulses align with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            clean_out  <= clean_nxt;
            rise_pulse <= clean_nxt & ~clean_out;
            fall_pulse <= ~clean_nxt & clean_out;
            any_change <= |(clean_nxt ^ clean_out);
        end
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed scenarios with hand-derived expectations,
// plus randomized chatter checked against a run-length reference model.
module tb_multi_debounce;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int RISE = 8;
    localparam int FALL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] noisy_in = '0;
    logic [CH-1:0] clean_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_change;

    int total = 0;
    int bad   = 0;

    multi_debounce #(
        .CHANNELS(CH), .CNT_W(8), .RISE_CYCLES(RISE), .FALL_CYCLES(FALL), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .noisy_in(noisy_in), .clean_out(clean_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
    );

    always #5 clk = ~clk;

    // Reference model: a channel flips once the delayed input has disagreed with
    // the clean level for threshold+1 consecutive sampling edges.
    logic [CH-1:0] m_pipe [SYNC];
    logic [CH-1:0] m_s;
    logic [CH-1:0] m_clean = '0;
    logic [CH-1:0] m_rise  = '0;
    logic [CH-1:0] m_fall  = '0;
    logic          m_any   = 1'b0;
    int            m_run [CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
            m_clean = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        end else begin
            m_s = m_pipe[SYNC-1];
            for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = noisy_in;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < CH; c++) begin
                if (m_s[c] !== m_clean[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == (m_clean[c] ? FALL : RISE) + 1) begin
                        m_clean[c] = ~m_clean[c];
                        m_run[c]   = 0;
                        if (m_clean[c]) m_rise[c] = 1'b1;
                        else            m_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_any = |(m_rise | m_fall);
        end
    end

    // Advance one clock: returns at the falling edge, one rising edge later.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] obs, exp;
        noisy_in = 4'hF;
        #3 rst_n = 1'b0;
        #1;
        obs = {clean_out, rise_pulse, fall_pulse, any_change};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", obs, 13'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {(k >= 11) ? 4'hF : 4'h0, (k == 11) ? 4'hF : 4'h0, 4'h0, k == 11};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_release edge %0d: got %h want %h", k, obs, exp);
            end
        end
        noisy_in = 4'h0;
        repeat (10) cyc();
    endtask

    task automatic test_press();
        logic [12:0] obs, exp;
        noisy_in[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {(k >= 11) ? 4'h1 : 4'h0, (k == 11) ? 4'h1 : 4'h0, 4'h0, k == 11};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL press edge %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [12:0] obs, exp;
        for (int k = 1; k <= 26; k++) begin
            noisy_in[1] = (k == 6) ? 1'b0 : 1'b1;
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {(k >= 17) ? 4'h3 : 4'h1, (k == 17) ? 4'h2 : 4'h0, 4'h0, k == 17};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce edge %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [12:0] obs, exp;
        noisy_in[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {(k >= 7) ? 4'h2 : 4'h3, 4'h0, (k == 7) ? 4'h1 : 4'h0, k == 7};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL release edge %0d: got %h want %h", k, obs, exp);
            end
        end
        noisy_in[0] = 1'b1;
        repeat (12) cyc();
        total++;
        if (clean_out !== 4'h3) begin
            bad++;
            $display("FAIL repress: got %h want %h", clean_out, 4'h3);
        end
        for (int k = 1; k <= 14; k++) begin
            noisy_in[0] = (k <= 2) ? 1'b0 : 1'b1;
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {4'h3, 4'h0, 4'h0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL glitch edge %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [12:0] obs, exp;
        int          any_cnt;
        any_cnt = 0;
        noisy_in[3:2] = 2'b11;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (any_change === 1'b1) any_cnt++;
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {(k >= 11) ? 4'hF : 4'h3, (k == 11) ? 4'hC : 4'h0, 4'h0, k == 11};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL simultaneous edge %0d: got %h want %h", k, obs, exp);
            end
        end
        total++;
        if (any_cnt !== 1) begin
            bad++;
            $display("FAIL any_change_count: got %0d want %0d", any_cnt, 1);
        end
    endtask

    task automatic test_reset_midwait();
        logic [12:0] obs, exp;
        noisy_in = 4'h0;
        repeat (10) cyc();
        noisy_in[0] = 1'b1;
        // Edge 3 enters the high wait with count 0; edge 8 leaves the count at 5.
        repeat (8) cyc();
        rst_n = 1'b0;
        #1;
        obs = {clean_out, rise_pulse, fall_pulse, any_change};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL midwait_reset: got %h want %h", obs, 13'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {(k >= 11) ? 4'h1 : 4'h0, (k == 11) ? 4'h1 : 4'h0, 4'h0, k == 11};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midwait_release edge %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] obs, exp;
        int          odds;
        for (int k = 0; k < 800; k++) begin
            // Alternate between chattering and calm phases so both outcomes occur.
            odds = ((k / 100) % 2 == 0) ? 3 : 25;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(odds - 1, 0) == 0) noisy_in[c] = ~noisy_in[c];
            end
            cyc();
            obs = {clean_out, rise_pulse, fall_pulse, any_change};
            exp = {m_clean, m_rise, m_fall, m_any};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random cycle %0d: got %h want %h", k, obs, exp);
            end
            total++;
            if ((rise_pulse & fall_pulse) !== 4'h0) begin
                bad++;
                $display("FAIL pulse_exclusive cycle %0d: got %h want %h", k, rise_pulse & fall_pulse, 4'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
